// File: rtl/six_lane_mon_pkg.sv
// Shared constants and helpers for the six-lane response monitor.
// MISR constants are only consumed when MONITOR_MISR_EN is defined.
package six_lane_mon_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  // Record layout: {timestamp, change mask, lane data}
  function automatic int rec_w(input int lanes,
                               input int width,
                               input int ts_w);
    return ts_w + lanes + lanes * width;
  endfunction

  function automatic logic [31:0] misr_next(
    input logic [31:0] m,
    input logic [31:0] fold
  );
    return {m[30:0], 1'b0}
         ^ (m[31] ? MISR_POLY : 32'h0)
         ^ fold;
  endfunction

endpackage

// File: rtl/mon_event_fifo.sv
// Synchronous FIFO for change records.
// Full/empty come from an extra wrap bit on each pointer.
module mon_event_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_pop;
  logic         do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
              && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop in the same cycle frees the slot the push needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr <= wptr + (AW+1)'(1);
      end
      if (do_pop)
        rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/six_lane_response_monitor.sv
// Six-lane change monitor with timestamped event FIFO.
// Define MONITOR_MISR_EN to add the running sample signature (misr).
module six_lane_response_monitor
  import six_lane_mon_pkg::*;
#(
  parameter int LANES = 6,
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] lanes,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_W-1:0]        ev_time,
  output logic [LANES-1:0]       ev_mask,
  output logic [LANES*WIDTH-1:0] ev_data,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
`ifdef MONITOR_MISR_EN
  ,
  output logic [31:0]            misr
`endif
);

  localparam int DW = LANES * WIDTH;
  localparam int RW = rec_w(LANES, WIDTH, TS_W);

  logic [0:0]      state;
  logic [DW-1:0]   prev;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_nxt;
  logic [LANES-1:0] mask;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [RW-1:0]   rdata;

  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++)
      mask[i] = lanes[i*WIDTH +: WIDTH]
             != prev[i*WIDTH +: WIDTH];
  end

  assign ts_nxt   = ts + TS_W'(1);
  assign push     = (state == RUN) && en && |mask;
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;

  mon_event_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({ts_nxt, mask, lanes}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign {ev_time, ev_mask, ev_data} = rdata;

  // First enabled sample is the baseline at ts 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev  <= '0;
      ts    <= '0;
    end else if (en) begin
      state <= RUN;
      prev  <= lanes;
      ts    <= (state == RUN) ? ts_nxt : '0;
    end else begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef MONITOR_MISR_EN
  logic [31:0] fold;

  assign fold = lanes[31:0] ^ 32'(lanes >> 32);

  always_ff @(posedge clk) begin
    if (rst)
      misr <= MISR_SEED;
    else if (en)
      misr <= misr_next(misr, fold);
  end
`endif

endmodule

// File: tb/tb_six_lane_response_monitor.sv
// Randomised + directed bench for six_lane_response_monitor.
// Reference: a record queue advanced once per clock edge.
module tb_six_lane_response_monitor;

  localparam int LANES = 6;
  localparam int WIDTH = 7;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
  localparam int DW    = LANES * WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [DW-1:0]   lanes;
  logic            ev_valid;
  logic            ev_ready;
  logic [TS_W-1:0] ev_time;
  logic [LANES-1:0] ev_mask;
  logic [DW-1:0]   ev_data;
  logic            overflow;
  logic [7:0]      drop_cnt;
`ifdef MONITOR_MISR_EN
  logic [31:0]     misr;
`endif

  six_lane_response_monitor #(
    .LANES (LANES),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lanes    (lanes),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_time  (ev_time),
    .ev_mask  (ev_mask),
    .ev_data  (ev_data),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
`ifdef MONITOR_MISR_EN
    ,
    .misr     (misr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TS_W-1:0]  t;
    logic [LANES-1:0] m;
    logic [DW-1:0]    d;
  } rec_t;

  rec_t        q[$];
  bit          m_run;
  int          m_ts;
  logic [DW-1:0] m_prev;
  bit          m_ovf;
  int          m_drop;
  logic [31:0] m_misr;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rep(input logic [6:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*WIDTH +: WIDTH] = v;
    return r;
  endfunction

  function automatic logic [31:0] sig_step(
    input logic [31:0] s,
    input logic [DW-1:0] l
  );
    logic [31:0] hi;
    logic [31:0] nx;
    hi = '0;
    for (int b = 32; b < DW; b++)
      hi[b-32] = l[b];
    nx = s << 1;
    if (s[31]) nx = nx ^ 32'h04C1_1DB7;
    return nx ^ l[31:0] ^ hi;
  endfunction

  task automatic model_edge();
    bit   do_pop;
    bit   has_rec;
    rec_t r;
    do_pop  = (q.size() != 0) && ev_ready;
    has_rec = 0;
    if (rst) begin
      q.delete();
      m_run  = 0;
      m_ts   = 0;
      m_prev = '0;
      m_ovf  = 0;
      m_drop = 0;
      m_misr = 32'hFFFF_FFFF;
      return;
    end
    if (en) begin
      if (m_run) begin
        m_ts = (m_ts + 1) % (1 << TS_W);
        r.t = m_ts[TS_W-1:0];
        r.d = lanes;
        r.m = '0;
        for (int i = 0; i < LANES; i++)
          if (lanes[i*WIDTH +: WIDTH] != m_prev[i*WIDTH +: WIDTH])
            r.m[i] = 1'b1;
        has_rec = (r.m != 0);
      end else begin
        m_ts = 0;
      end
      m_misr = sig_step(m_misr, lanes);
      m_prev = lanes;
      m_run  = 1;
    end else begin
      m_run = 0;
    end
    if (do_pop) void'(q.pop_front());
    if (has_rec) begin
      if (q.size() < DEPTH) begin
        q.push_back(r);
      end else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 64'(ev_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("time", 64'(ev_time), 64'(q[0].t));
      check("mask", 64'(ev_mask), 64'(q[0].m));
      check("data", 64'(ev_data), 64'(q[0].d));
    end
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`ifdef MONITOR_MISR_EN
    check("misr", 64'(misr), 64'(m_misr));
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    lanes    = '0;
    ev_ready = 1'b0;
    tick();
    check("rst_valid", 64'(ev_valid), 64'd0);
    check("rst_time", 64'(ev_time), 64'd0);
    check("rst_mask", 64'(ev_mask), 64'd0);
    check("rst_data", 64'(ev_data), 64'd0);
`ifdef MONITOR_MISR_EN
    check("rst_misr", 64'(misr), 64'hFFFF_FFFF);
`endif
    rst = 1'b0;

    // Quiet lanes: baseline plus three samples
    en = 1'b1;
    repeat (4) tick();
    check("quiet_valid", 64'(ev_valid), 64'd0);
    lanes = rep(7'h01);
    tick();
    check("quiet_ts4", 64'(ev_time), 64'd4);

    // All lanes to 3F at ts 2
    rst = 1'b1; tick(); rst = 1'b0;
    lanes = '0;
    tick();
    tick();
    lanes = rep(7'h3F);
    tick();
    check("all_time", 64'(ev_time), 64'd2);
    check("all_mask", 64'(ev_mask), 64'h3F);
    check("all_data", 64'(ev_data), 64'(rep(7'h3F)));

    ev_ready = 1'b1;
    lanes[3*WIDTH +: WIDTH] = 7'h00;
    tick();
    check("l3_mask", 64'(ev_mask), 64'b001000);
    lanes[4*WIDTH +: WIDTH] = 7'h30;
    lanes[5*WIDTH +: WIDTH] = 7'h38;
    tick();
    check("l45_mask", 64'(ev_mask), 64'b110000);
    tick();

    // Overflow: ten records into eight slots
    rst = 1'b1; tick(); rst = 1'b0;
    ev_ready = 1'b0;
    lanes = '0;
    tick();
    for (int k = 0; k < 10; k++) begin
      lanes = ~lanes;
      tick();
    end
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    en = 1'b0;
    ev_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_time", 64'(ev_time), 64'(k + 1));
      tick();
    end
    check("drain_empty", 64'(ev_valid), 64'd0);

    // Full FIFO with a simultaneous pop: nothing dropped
    en = 1'b1;
    ev_ready = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      lanes = ~lanes;
      tick();
    end
    ev_ready = 1'b1;
    lanes = ~lanes;
    tick();
    check("full_pp_drop", 64'(drop_cnt), 64'd2);
    check("full_pp_valid", 64'(ev_valid), 64'd1);

    // Fixed eight-sample run, then reset mid-run
    rst = 1'b1; tick(); rst = 1'b0;
    ev_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lanes = {10'(k * 37), 32'h1357_9BDF ^ 32'(k * 32'h0101_0101)};
      tick();
    end
    lanes = ~lanes;
    rst = 1'b1;
    tick();
    check("midrst_valid", 64'(ev_valid), 64'd0);
    check("midrst_drop", 64'(drop_cnt), 64'd0);
`ifdef MONITOR_MISR_EN
    check("midrst_misr", 64'(misr), 64'hFFFF_FFFF);
`endif
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 7) != 0);
      ev_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < LANES; i++)
        if ($urandom_range(0, 3) == 0)
          lanes[i*WIDTH +: WIDTH] = 7'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
